ser_frame_tx: RTL
=================

SER_FRAME_TX -- requirements
Module: ser_frame_tx

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8: bits per frame, at least 1.
- CLK_DIV, 4: system clocks per serial bit period; even and at least 2.
- TRANS_EDGE, 1: 1 = data updates at ser_clk rising edge; 0 = data updates at falling edge.
- MSB_FIRST, 1: 1 = bit DATA_WIDTH-1 first; 0 = bit 0 first.
- MID_CYCLE, 0: 1 = data updates in the middle of the active half-period instead of on the edge.
- IDLE_BITS, 1: bit periods of idle gap after each frame; at least 0.

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, in, 1: the single clock.
- rstn, in, 1: asynchronous active-low reset.
- tx_data, in, DATA_WIDTH: frame word.
- tx_valid, in, 1: tx_data is offered.
- tx_ready, out, 1: block can accept a word.
- repeat_en, in, 1: retransmit the held word after each gap.
- ser_clk, out, 1: serial clock aligned to the data.
- ser_data, out, 1: serial data.
- busy, out, 1: high in SHIFT and GAP.
- frame_done, out, 1: one-cycle pulse at the end of each frame.

REQ-003 The block SHALL be synthesizable: no delays and no initial blocks.

REQ-004 An illegal parameter combination SHALL cause an elaboration error. Illegal combinations are:
- CLK_DIV odd or less than 2;
- MID_CYCLE=1 with CLK_DIV not a multiple of 4.

Function
REQ-005 The FSM SHALL have three states: IDLE, SHIFT, GAP.
REQ-006 IDLE: tx_ready=1, ser_clk=1 and ser_data=1 are held.
REQ-007 The handshake (tx_valid and tx_ready on a rising clk edge) SHALL:
- latch tx_data into the held register;
- enter SHIFT on the next cycle, with the bit counter and the divide counter both at 0.
REQ-008 tx_ready SHALL be 0 in SHIFT and GAP; tx_data is ignored outside the handshake.
REQ-009 Each bit period SHALL be CLK_DIV cycles with half-period HALF=CLK_DIV/2.
- TRANS_EDGE=1: ser_clk is 0 for the first HALF cycles and 1 for the second HALF cycles.
- TRANS_EDGE=0: ser_clk is 1 for the first HALF cycles and 0 for the second HALF cycles.
REQ-010 With MID_CYCLE=0, ser_data SHALL change in the same cycle as the second-half ser_clk transition (divide count = HALF).
REQ-011 With MID_CYCLE=1, ser_data SHALL change at divide count HALF+HALF/2.
REQ-012 Bit order SHALL follow MSB_FIRST.
- A frame lasts exactly DATA_WIDTH*CLK_DIV cycles.
- The held word is not modified while a frame is in progress.
REQ-013 frame_done SHALL pulse for exactly 1 cycle on the last cycle of the final bit period.
REQ-014 GAP SHALL last IDLE_BITS*CLK_DIV cycles, holding ser_clk=1 and the last data bit.
- With IDLE_BITS=0, GAP is skipped.
REQ-015 At the end of GAP:
- repeat_en=1: enter SHIFT and resend the held word;
- repeat_en=0: return to IDLE, where ser_data returns to 1.
REQ-016 repeat_en SHALL be sampled only at the GAP exit. Deasserting it mid-frame lets the current frame and gap finish.
REQ-017 The first tx_valid SHALL be accepted in the IDLE cycle following GAP exit.
- Back-to-back frames are therefore separated by the gap plus 1 IDLE cycle.
REQ-018 The divide counter SHALL wrap from CLK_DIV-1 to 0.
- The bit counter width is clog2(DATA_WIDTH), minimum 1.
- The gap counter width covers IDLE_BITS*CLK_DIV.

Reset
REQ-019 Assertion of rstn=0 SHALL immediately force, asynchronously, including in the middle of a frame:
- state=IDLE; all counters and the held register to 0;
- ser_clk=1, ser_data=1, tx_ready=1, busy=0, frame_done=0.
REQ-020 The block SHALL start accepting on the first rising clk edge after rstn deasserts; no partial frame resumes.

Structure
REQ-021 Package ser_tx_pkg SHALL hold the state enum typedef ser_tx_state_t and the counter-width helper functions.
REQ-022 Bit-period timing (divide counter, edge strobe, data-update strobe, period-end strobe) SHALL live in sub-module ser_bit_timer, parametrised by CLK_DIV, TRANS_EDGE and MID_CYCLE.
REQ-023 All outputs SHALL be registered.

Verification
REQ-024 The bench SHALL cover these directed scenarios, all with DATA_WIDTH=8 and CLK_DIV=4 unless noted:
- MSB_FIRST=1, 0xA5 -> ser_data at rising edges 1,0,1,0,0,1,0,1; one frame_done pulse 32 cycles after the handshake; then IDLE.
- MSB_FIRST=0, TRANS_EDGE=0, 0x85 -> bits 1,0,1,0,0,0,0,1 change coincident with ser_clk falling edges.
- MID_CYCLE=1, CLK_DIV=8 -> every ser_data change occurs 2 cycles after the active ser_clk edge, never at an edge.
- repeat_en=1, 0x3C, IDLE_BITS=2 -> three identical frames with 8-cycle gaps; repeat_en dropped during frame 3 -> return to IDLE after gap 3; tx_ready=0 throughout.
- rstn pulsed low at bit 4 -> outputs take reset values in the same cycle; a new word 0x5A after reset is sent in full.
- tx_valid held high with words 0x01, 0x02 -> 0x02 accepted exactly 1 cycle after the first gap ends; busy is low for exactly that 1 cycle.

Source files
------------

// File: rtl/ser_tx_pkg.sv
// Shared types and sizing helpers for the serial frame transmitter.
package ser_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_tx_state_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Gap counter must be able to represent the full gap length, even when zero.
    function automatic int gap_width(input int idle_bits, input int clk_div);
        return cnt_width(idle_bits * clk_div + 1);
    endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period timing: divide counter, serial clock level and the per-period strobes.
// Strobes with a _d suffix describe the NEXT cycle so the parent can register its
// outputs and still have them line up with the divide count.
module ser_bit_timer
    import ser_tx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int TRANS_EDGE = 1,
    parameter int MID_CYCLE  = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic advance_i,     // currently shifting: divide counter runs this cycle
    input  logic run_i,         // shifting in the next cycle
    output logic ser_clk_o,     // registered serial clock
    output logic upd_d_o,       // next cycle is the data-update point
    output logic last_d_o,      // next cycle is the last of a bit period
    output logic period_end_o   // current cycle is the last of a bit period
);
    localparam int HALF    = CLK_DIV / 2;
    localparam int UPD_CNT = (MID_CYCLE != 0) ? HALF + HALF / 2 : HALF;
    localparam int DIV_W   = cnt_width(CLK_DIV);

    localparam logic [DIV_W-1:0] HALF_CNT = DIV_W'(HALF);
    localparam logic [DIV_W-1:0] UPD_VAL  = DIV_W'(UPD_CNT);
    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);
    localparam logic FIRST_LVL  = (TRANS_EDGE == 0);
    localparam logic SECOND_LVL = (TRANS_EDGE != 0);

    if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_div
        $error("ser_bit_timer: CLK_DIV must be even and at least 2");
    end
    if ((MID_CYCLE != 0) && (CLK_DIV % 4 != 0)) begin : g_bad_mid
        $error("ser_bit_timer: MID_CYCLE needs CLK_DIV to be a multiple of 4");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             ser_clk_q, ser_clk_d;
    logic             start_d, edge_d;

    // Divide counter advances only while shifting and restarts at 0 for every new frame.
    always_comb begin
        div_d = '0;
        if (advance_i && (div_q != LAST_CNT)) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    assign start_d      = (div_d == '0);
    assign edge_d       = (div_d == HALF_CNT);
    assign upd_d_o      = (div_d == UPD_VAL);
    assign last_d_o     = (div_d == LAST_CNT);
    assign period_end_o = advance_i && (div_q == LAST_CNT);

    // Serial clock: first-half level at period start, flips at the half point, 1 when not shifting.
    always_comb begin
        ser_clk_d = ser_clk_q;
        if (!run_i) begin
            ser_clk_d = 1'b1;
        end else if (start_d) begin
            ser_clk_d = FIRST_LVL;
        end else if (edge_d) begin
            ser_clk_d = SECOND_LVL;
        end
    end

    // Counter and serial-clock registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q     <= '0;
            ser_clk_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            ser_clk_q <= ser_clk_d;
        end
    end

    assign ser_clk_o = ser_clk_q;

endmodule

// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: accepts a word, shifts it out with an aligned serial
// clock, optionally idles for a gap and repeats the held word.
module ser_frame_tx
    import ser_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int TRANS_EDGE = 1,
    parameter int MSB_FIRST  = 1,
    parameter int MID_CYCLE  = 0,
    parameter int IDLE_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  repeat_en,
    output logic                  ser_clk,
    output logic                  ser_data,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int GAP_LEN  = IDLE_BITS * CLK_DIV;
    localparam int GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
    localparam int BIT_W    = cnt_width(DATA_WIDTH);
    localparam int GAP_W    = gap_width(IDLE_BITS, CLK_DIV);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("ser_frame_tx: DATA_WIDTH must be at least 1");
    end
    if (IDLE_BITS < 0) begin : g_bad_idle
        $error("ser_frame_tx: IDLE_BITS must not be negative");
    end

    ser_tx_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] held_q, held_d;
    logic [BIT_W-1:0]      bit_q, bit_d, bit_idx;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  ser_data_q, ser_data_d;
    logic                  tx_ready_q, busy_q, frame_done_q, frame_done_d;
    logic                  upd_d, last_d, period_end;

    ser_bit_timer #(
        .CLK_DIV    (CLK_DIV),
        .TRANS_EDGE (TRANS_EDGE),
        .MID_CYCLE  (MID_CYCLE)
    ) u_timer (
        .clk          (clk),
        .rstn         (rstn),
        .advance_i    (state_q == ST_SHIFT),
        .run_i        (state_d == ST_SHIFT),
        .ser_clk_o    (ser_clk),
        .upd_d_o      (upd_d),
        .last_d_o     (last_d),
        .period_end_o (period_end)
    );

    // Next-state logic: handshake, bit stepping, gap timing and the repeat decision.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d = ST_SHIFT;
                    held_d  = tx_data;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (period_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        gap_d = '0;
                        if (GAP_LEN == 0) begin
                            state_d = repeat_en ? ST_SHIFT : ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_END) begin
                    gap_d   = '0;
                    state_d = repeat_en ? ST_SHIFT : ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bit_idx = (MSB_FIRST != 0) ? (LAST_BIT - bit_d) : bit_d;

    // Output next values are derived from next state so registered outputs align with the counters.
    always_comb begin
        ser_data_d   = ser_data_q;
        frame_done_d = 1'b0;
        if (state_d == ST_IDLE) begin
            ser_data_d = 1'b1;
        end else if (state_d == ST_SHIFT) begin
            if (upd_d) begin
                ser_data_d = held_d[bit_idx];
            end
            frame_done_d = last_d && (bit_d == LAST_BIT);
        end
    end

    // State, counters, held word and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            held_q       <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            ser_data_q   <= 1'b1;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            ser_data_q   <= ser_data_d;
            tx_ready_q   <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_data   = ser_data_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
